// File: rtl/writeback_regfile_pkg.sv
// Shared constants and the EX_WB stage-register layout for the write-back end of the pipeline.
package writeback_regfile_pkg;

   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int PEND_W     = 2;

   typedef struct packed {
      logic [XLEN-1:0]       alu_result;
      logic                  alu_result_ready;
      logic [REG_ADDR_W-1:0] reg_wr_addr;
      logic                  reg_wr_en;
   } ex_wb_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// Execute/decode facing bus of the write-back block: EX_WB input, read ports and issue handshake.
interface writeback_regfile_if;
   import writeback_regfile_pkg::*;

   ex_wb_t                ex_wb_reg;
   logic [REG_ADDR_W-1:0] rs1_addr;
   logic [REG_ADDR_W-1:0] rs2_addr;
   logic [XLEN-1:0]       rs1_data;
   logic [XLEN-1:0]       rs2_data;
   logic                  issue_valid;
   logic [REG_ADDR_W-1:0] issue_rd;
   logic                  issue_rd_en;
   logic                  stall;

   modport master (
      output ex_wb_reg, rs1_addr, rs2_addr, issue_valid, issue_rd, issue_rd_en,
      input  rs1_data, rs2_data, stall
   );

   modport slave (
      input  ex_wb_reg, rs1_addr, rs2_addr, issue_valid, issue_rd, issue_rd_en,
      output rs1_data, rs2_data, stall
   );

endinterface

// File: rtl/writeback_regfile_2r1w.sv
// Two-read/one-write integer register file; x0 reads as zero, a same-cycle write is bypassed to reads.
module writeback_regfile_2r1w
   import writeback_regfile_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]       rs1_data,
   output logic [XLEN-1:0]       rs2_data
);

   logic [XLEN-1:0] mem [1:NUM_REGS-1];
   logic            we_nz;

   assign we_nz = we && (wr_addr != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i < NUM_REGS; i++) mem[i] <= '0;
      end else if (we_nz) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rs1_data = '0;
      if (rs1_addr == '0)                     rs1_data = '0;
      else if (we_nz && rs1_addr == wr_addr)  rs1_data = wr_data;
      else                                    rs1_data = mem[rs1_addr];
   end

   always_comb begin
      rs2_data = '0;
      if (rs2_addr == '0)                     rs2_data = '0;
      else if (we_nz && rs2_addr == wr_addr)  rs2_data = wr_data;
      else                                    rs2_data = mem[rs2_addr];
   end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: commits EX_WB results, tracks pending writes per register for decode stalls,
// and exports a one-cycle-delayed commit trace plus a retire counter.
module writeback_regfile
   import writeback_regfile_pkg::*;
#(
   parameter int RET_W = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   writeback_regfile_if.slave    bus,
   output logic                  wb_valid,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic [XLEN-1:0]       wb_data,
   output logic [RET_W-1:0]      retired_count,
   output logic                  sb_error
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   logic                  we;
   logic [REG_ADDR_W-1:0] wr_addr;
   logic                  inc;
   logic                  eff_rs1;
   logic                  eff_rs2;
   logic                  rd_full;
   logic [PEND_W-1:0]     pend     [1:NUM_REGS-1];
   logic [PEND_W-1:0]     pend_all [NUM_REGS];

   assign wr_addr = bus.ex_wb_reg.reg_wr_addr;
   assign we      = bus.ex_wb_reg.alu_result_ready && bus.ex_wb_reg.reg_wr_en && (wr_addr != '0);

   writeback_regfile_2r1w u_rf (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (we),
      .wr_addr  (wr_addr),
      .wr_data  (bus.ex_wb_reg.alu_result),
      .rs1_addr (bus.rs1_addr),
      .rs2_addr (bus.rs2_addr),
      .rs1_data (bus.rs1_data),
      .rs2_data (bus.rs2_data)
   );

   always_comb begin
      pend_all[0] = '0;
      for (int i = 1; i < NUM_REGS; i++) pend_all[i] = pend[i];
   end

   // A write landing this cycle clears the last pending entry, matching what the bypass delivers.
   always_comb begin
      eff_rs1 = (pend_all[bus.rs1_addr] != '0) &&
                !(pend_all[bus.rs1_addr] == PEND_ONE && we && wr_addr == bus.rs1_addr);
      eff_rs2 = (pend_all[bus.rs2_addr] != '0) &&
                !(pend_all[bus.rs2_addr] == PEND_ONE && we && wr_addr == bus.rs2_addr);
      rd_full = bus.issue_rd_en && (pend_all[bus.issue_rd] == PEND_MAX) &&
                !(we && wr_addr == bus.issue_rd);
      bus.stall = bus.issue_valid && (eff_rs1 || eff_rs2 || rd_full);
   end

   assign inc = bus.issue_valid && !bus.stall && bus.issue_rd_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i < NUM_REGS; i++) pend[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (inc && bus.issue_rd == REG_ADDR_W'(i) && !(we && wr_addr == REG_ADDR_W'(i)))
               pend[i] <= pend[i] + PEND_ONE;
            else if (we && wr_addr == REG_ADDR_W'(i) && !(inc && bus.issue_rd == REG_ADDR_W'(i))
                     && pend[i] != '0)
               pend[i] <= pend[i] - PEND_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sb_error      <= 1'b0;
         retired_count <= '0;
         wb_valid      <= 1'b0;
         wb_addr       <= '0;
         wb_data       <= '0;
      end else begin
         if (we && pend_all[wr_addr] == '0) sb_error <= 1'b1;
         if (bus.ex_wb_reg.alu_result_ready) retired_count <= retired_count + RET_W'(1);
         wb_valid <= we;
         if (we) begin
            wb_addr <= wr_addr;
            wb_data <= bus.ex_wb_reg.alu_result;
         end
      end
   end

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized bench for writeback_regfile against an array-based reference of the commit/scoreboard rules.
module tb_writeback_regfile;
   import writeback_regfile_pkg::*;

   localparam int PMAX = 3;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] retired_count;
   logic        sb_error;

   always #5 clk = ~clk;

   writeback_regfile_if bus ();

   writeback_regfile #(.RET_W(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .retired_count (retired_count),
      .sb_error      (sb_error)
   );

   logic [31:0] m_regs [32];
   int          m_pend [32];
   bit          m_err;
   logic [31:0] m_ret;
   bit          m_wbv;
   logic [4:0]  m_wba;
   logic [31:0] m_wbd;
   int          n_chk;
   int          n_pass;
   logic [31:0] last_rs1;
   logic        last_stall;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 0;
      end
      m_err = 0; m_ret = '0; m_wbv = 0; m_wba = '0; m_wbd = '0;
   endtask

   function automatic logic [31:0] m_read(input int a, input bit we, input int wa, input logic [31:0] res);
      if (a == 0) return '0;
      if (we && a == wa) return res;
      return m_regs[a];
   endfunction

   function automatic bit m_eff(input int a, input bit we, input int wa);
      return (m_pend[a] != 0) && !(m_pend[a] == 1 && we && wa == a);
   endfunction

   task automatic drive_idle();
      bus.ex_wb_reg   = '0;
      bus.rs1_addr    = '0;
      bus.rs2_addr    = '0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
      bus.issue_rd_en = 1'b0;
   endtask

   task automatic check_regs_out();
      chk("wb_valid", 32'(wb_valid), 32'(m_wbv));
      chk("wb_addr", 32'(wb_addr), 32'(m_wba));
      chk("wb_data", wb_data, m_wbd);
      chk("retired", retired_count, m_ret);
      chk("sb_error", 32'(sb_error), 32'(m_err));
   endtask

   // One clock: drive at posedge+1, check comb outputs, then advance the model across the edge.
   task automatic cyc(input bit rdy, input bit wen, input logic [4:0] wa, input logic [31:0] res,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input bit iv, input logic [4:0] rd, input bit rden);
      bit          we;
      bit          e_stall;
      bit          inc;
      logic [31:0] e1;
      logic [31:0] e2;
      bus.ex_wb_reg.alu_result       = res;
      bus.ex_wb_reg.alu_result_ready = rdy;
      bus.ex_wb_reg.reg_wr_addr      = wa;
      bus.ex_wb_reg.reg_wr_en        = wen;
      bus.rs1_addr    = r1;
      bus.rs2_addr    = r2;
      bus.issue_valid = iv;
      bus.issue_rd    = rd;
      bus.issue_rd_en = rden;
      #1;
      we      = rdy && wen && (wa != 0);
      e1      = m_read(int'(r1), we, int'(wa), res);
      e2      = m_read(int'(r2), we, int'(wa), res);
      e_stall = iv && (m_eff(int'(r1), we, int'(wa)) || m_eff(int'(r2), we, int'(wa)) ||
                       (rden && m_pend[rd] == PMAX && !(we && wa == rd)));
      chk("rs1_data", bus.rs1_data, e1);
      chk("rs2_data", bus.rs2_data, e2);
      chk("stall", 32'(bus.stall), 32'(e_stall));
      last_rs1   = bus.rs1_data;
      last_stall = bus.stall;
      inc = iv && !e_stall && rden && (rd != 0);
      @(posedge clk);
      #1;
      if (rdy) m_ret = m_ret + 1;
      m_wbv = we;
      if (we) begin
         m_wba = wa;
         m_wbd = res;
         m_regs[wa] = res;
         if (m_pend[wa] == 0) m_err = 1;
         else if (!(inc && rd == wa)) m_pend[wa]--;
      end
      if (inc && !(we && rd == wa)) m_pend[rd]++;
      check_regs_out();
   endtask

   task automatic random_run(input int n);
      logic [4:0] wa, r1, r2, rd;
      for (int k = 0; k < n; k++) begin
         wa = 5'(($urandom % 5 == 0) ? $urandom % 32 : $urandom % 8);
         r1 = 5'($urandom % 8);
         r2 = 5'(($urandom % 3 == 0) ? $urandom % 32 : $urandom % 8);
         rd = 5'($urandom % 8);
         cyc(($urandom % 4) != 0, ($urandom % 3) != 0, wa, $urandom, r1, r2,
             ($urandom % 2) != 0, rd, ($urandom % 4) != 0);
      end
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      model_reset();
      drive_idle();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset state and zero reads.
      check_regs_out();
      cyc(0, 0, 0, 0, 5, 0, 0, 0, 0);
      chk("rst_rs1", last_rs1, 32'h0);

      // Issue rd=5, then commit 5 with same-cycle bypass.
      cyc(0, 0, 0, 0, 0, 0, 1, 5, 1);
      cyc(1, 1, 5, 32'h1234, 5, 0, 0, 0, 0);
      chk("bypass5", last_rs1, 32'h1234);
      chk("wb_addr5", 32'(wb_addr), 32'd5);
      chk("wb_data5", wb_data, 32'h1234);
      cyc(0, 0, 0, 0, 5, 0, 0, 0, 0);
      chk("reg5", last_rs1, 32'h1234);

      // Write to x0 is dropped but retires.
      cyc(1, 1, 0, 32'hdeadbeef, 0, 0, 0, 0, 0);
      chk("x0_rd", last_rs1, 32'h0);
      chk("x0_wbv", 32'(wb_valid), 32'h0);

      // RAW hazard on 7 resolved by a same-cycle write.
      cyc(0, 0, 0, 0, 0, 0, 1, 7, 1);
      cyc(0, 0, 0, 0, 7, 0, 1, 0, 0);
      chk("raw7_stall", 32'(last_stall), 32'h1);
      cyc(1, 1, 7, 32'h77, 7, 0, 1, 0, 0);
      chk("raw7_release", 32'(last_stall), 32'h0);
      chk("raw7_byp", last_rs1, 32'h77);
      cyc(0, 0, 0, 0, 7, 0, 1, 0, 0);
      chk("pend7_clear", 32'(last_stall), 32'h0);

      // Pending counter saturation on 3.
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 3, 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 3, 1);
      chk("full3_stall", 32'(last_stall), 32'h1);
      cyc(1, 1, 3, 32'h33, 0, 0, 1, 3, 1);
      chk("full3_accept", 32'(last_stall), 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 1, 3, 1);
      chk("full3_still", 32'(last_stall), 32'h1);
      repeat (3) cyc(1, 1, 3, 32'h3300, 0, 0, 0, 0, 0);

      // Write-back with nothing pending sets the sticky error.
      chk("err_before", 32'(sb_error), 32'h0);
      cyc(1, 1, 9, 32'h99, 0, 0, 0, 0, 0);
      chk("err_set", 32'(sb_error), 32'h1);
      cyc(0, 0, 0, 0, 9, 0, 0, 0, 0);
      chk("err_sticky", 32'(sb_error), 32'h1);

      random_run(800);

      // Asynchronous reset between clock edges.
      drive_idle();
      bus.rs1_addr = 5'd5;
      bus.rs2_addr = 5'd3;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("arst_rs1", bus.rs1_data, 32'h0);
      chk("arst_rs2", bus.rs2_data, 32'h0);
      check_regs_out();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      random_run(800);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
